// File: rtl/mips_fetch.sv
// Instruction-fetch stage: owns the PC, keeps a credit-limited stream of word requests in flight,
// buffers responses in a FIFO for decode and redirects on branch/j/jr/except. Option: FETCH_EXC_VECTOR_EN.
module mips_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180,
  parameter int          DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [31:0] rs_data,
  output logic        halted
);

  // state | meaning
  // BOOT  | first cycle after reset, no requests
  // RUN   | fetching, requests limited by FIFO credit
  // HALT  | stopped after an exception, only draining stale responses

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] discard;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic          issue;
  logic          accept;
  logic          redirect;
  logic          push;
  logic          pop;
  logic [CW-1:0] credit_used;
  logic [31:0]   pc_plus4;
  logic [31:0]   br_offset;
  logic [31:0]   target;

  assign credit_used = outstanding + fifo_count;
  assign imem_req    = (state == RUN) && (credit_used < CW'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req && imem_gnt;

  assign inst_valid  = (fifo_count != '0);
  assign inst        = data_q[rd_ptr];
  assign inst_pc     = pc_q[rd_ptr];
  assign accept      = inst_valid && inst_ready;
  assign redirect    = accept && (except || (control_type != 2'b00));

  // A response landing in the redirect cycle belongs to the old stream and is flushed with it.
  assign push        = imem_rvalid && (discard == '0) && !redirect;
  assign pop         = accept && !redirect;

  assign pc_plus4    = inst_pc + 32'd4;
  assign br_offset   = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    target = rs_data;
    case (control_type)
      2'b01:   target = pc_plus4 + br_offset;
      2'b10:   target = {pc_plus4[31:28], inst[25:0], 2'b00};
      default: target = rs_data;
    endcase
    if (except) target = EXC_VECTOR;
  end

`ifdef FETCH_EXC_VECTOR_EN
  assign halted = 1'b0;
`else
  assign halted = (state == HALT);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      fifo_count  <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
`ifdef FETCH_EXC_VECTOR_EN
          state <= RUN;
`else
          if (accept && except) state <= HALT;
`endif
        end
        default: state <= state;
      endcase

      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);

      if (redirect) begin
        fetch_pc   <= target;
        rsp_pc     <= target;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        discard    <= discard + outstanding + CW'(issue) - CW'(imem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
        if (push) begin
          data_q[wr_ptr] <= imem_rdata;
          pc_q[wr_ptr]   <= rsp_pc;
          wr_ptr         <= wr_ptr + AW'(1);
          rsp_pc         <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
